tl_bus_arbiter: RTL and testbench

Round-robin arbiter that drives the one-hot select of the TileLink-style bus multiplexer and gates per-requester ready. It sits beside the bus mux on each shared channel (e.g. D-channel return path to the core, A-channel toward memory). It grants one requester at a time and holds the grant across a multi-beat burst until the last beat completes. It also flags bursts that overrun the configured maximum length.

---
 rtl/tl_bus_arbiter_pkg.sv | 14 +
 rtl/tl_bus_arbiter_rr_priority_pick.sv | 34 +++
 rtl/tl_bus_arbiter.sv | 113 +++++++++++
 tb/tb_tl_bus_arbiter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/tl_bus_arbiter_pkg.sv
// rtl/tl_bus_arbiter_pkg.sv - shared state encodings and sizing helpers for the bus arbiter
package tl_bus_arbiter_pkg;

    typedef logic [0:0] arb_state_t;

    localparam arb_state_t ST_IDLE   = 1'b0;
    localparam arb_state_t ST_LOCKED = 1'b1;

    // Beat counter must hold the value MAX_BEATS itself (saturation point).
    function automatic int beat_cnt_width(input int max_beats);
        return $clog2(max_beats) + 1;
    endfunction

endpackage

// File: rtl/tl_bus_arbiter_rr_priority_pick.sv
// rtl/tl_bus_arbiter_rr_priority_pick.sv - rotate-from-pointer first-one picker
module rr_priority_pick #(
    parameter int N  = 2,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [PW-1:0] idx
);

    logic found;
    int   j;

    // Scan from ptr upward, wrapping, and take the first asserted request.
    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        j      = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (req[j] && !found) begin
                found     = 1'b1;
                onehot[j] = 1'b1;
                idx       = j[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/tl_bus_arbiter.sv
// rtl/tl_bus_arbiter.sv - round-robin bus arbiter with burst lock and overrun flag
module tl_bus_arbiter
    import tl_bus_arbiter_pkg::*;
#(
    parameter  int N         = 2,
    parameter  int MAX_BEATS = 8,
    localparam int PW        = $clog2(N),
    localparam int BW        = beat_cnt_width(MAX_BEATS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [N-1:0]  io_in_valid,
    input  logic [N-1:0]  io_in_last,
    output logic [N-1:0]  io_in_ready,
    input  logic          io_out_ready,
    output logic          io_out_valid,
    output logic [N-1:0]  io_choseOH,
    output logic          io_locked,
    output logic [BW-1:0] io_beat_cnt,
    output logic          io_err_overrun
);

    arb_state_t    state_q;
    logic [PW-1:0] rr_ptr_q;
    logic [N-1:0]  grant_q;
    logic [BW-1:0] beat_cnt_q;
    logic          err_q;

    logic [N-1:0]  pick_oh;
    logic [PW-1:0] pick_idx;
    logic [PW-1:0] locked_idx;
    logic [N-1:0]  grant;
    logic [PW-1:0] grant_idx;
    logic [PW-1:0] next_ptr;
    logic          fire;
    logic          last;

    rr_priority_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req    (io_in_valid),
        .ptr    (rr_ptr_q),
        .onehot (pick_oh),
        .idx    (pick_idx)
    );

    // Index of the frozen grant, used to advance the pointer at burst end.
    always_comb begin
        locked_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) begin
                locked_idx = PW'(i);
            end
        end
    end

    // Live grant: picker result when idle, frozen grant during a burst; nothing while in reset.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        if (reset) begin
            if (state_q == ST_LOCKED) begin
                grant     = grant_q;
                grant_idx = locked_idx;
            end else begin
                grant     = pick_oh;
                grant_idx = pick_idx;
            end
        end
        next_ptr = (grant_idx == PW'(N - 1)) ? '0 : grant_idx + PW'(1);
    end

    assign io_choseOH     = grant;
    assign io_in_ready    = grant & {N{io_out_ready}};
    assign io_out_valid   = |(grant & io_in_valid);
    assign fire           = io_out_valid & io_out_ready;
    assign last           = |(grant & io_in_last);
    assign io_locked      = reset & (state_q == ST_LOCKED);
    assign io_beat_cnt    = beat_cnt_q;
    assign io_err_overrun = err_q;

    // Burst tracking: lock on a non-last fire, release and rotate on the last-beat fire.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else if (fire) begin
            if (last) begin
                state_q    <= ST_IDLE;
                rr_ptr_q   <= next_ptr;
                grant_q    <= '0;
                beat_cnt_q <= '0;
            end else if (state_q == ST_IDLE) begin
                state_q    <= ST_LOCKED;
                grant_q    <= grant;
                beat_cnt_q <= BW'(1);
            end else begin
                if (beat_cnt_q != BW'(MAX_BEATS)) begin
                    beat_cnt_q <= beat_cnt_q + BW'(1);
                end
                // Grant stays held after an overrun; only the flag records it.
                if (beat_cnt_q == BW'(MAX_BEATS - 1)) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tl_bus_arbiter.sv
// tb/tb_tl_bus_arbiter.sv - scoreboard bench for tl_bus_arbiter
module tb_tl_bus_arbiter;

    localparam int N         = 2;
    localparam int MAX_BEATS = 8;
    localparam int BW        = 4;

    logic          clock;
    logic          reset;
    logic [N-1:0]  io_in_valid;
    logic [N-1:0]  io_in_last;
    logic [N-1:0]  io_in_ready;
    logic          io_out_ready;
    logic          io_out_valid;
    logic [N-1:0]  io_choseOH;
    logic          io_locked;
    logic [BW-1:0] io_beat_cnt;
    logic          io_err_overrun;

    typedef struct {
        logic [1:0] oh;
        logic [1:0] rdy;
        logic       ov;
        logic       lock;
        logic [3:0] cnt;
        logic       err;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    tl_bus_arbiter #(
        .N         (N),
        .MAX_BEATS (MAX_BEATS)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .io_in_valid    (io_in_valid),
        .io_in_last     (io_in_last),
        .io_in_ready    (io_in_ready),
        .io_out_ready   (io_out_ready),
        .io_out_valid   (io_out_valid),
        .io_choseOH     (io_choseOH),
        .io_locked      (io_locked),
        .io_beat_cnt    (io_beat_cnt),
        .io_err_overrun (io_err_overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void check(input string nm, input string f, input logic [7:0] act, input logic [7:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fails++;
            $display("FAIL %s.%s actual=%0h expected=%0h", nm, f, act, expv);
        end
    endfunction

    // Drive one cycle of inputs; when chk is set, queue the values expected during that cycle.
    task automatic step(input logic rst, input logic [1:0] v, input logic [1:0] l, input logic ordy,
                        input logic chk, input logic [1:0] oh, input logic [1:0] rdy, input logic ov,
                        input logic lock, input logic [3:0] cnt, input logic err, input string nm);
        exp_t e;
        @(posedge clock);
        #1;
        reset        = rst;
        io_in_valid  = v;
        io_in_last   = l;
        io_out_ready = ordy;
        if (chk) begin
            e.oh = oh; e.rdy = rdy; e.ov = ov; e.lock = lock; e.cnt = cnt; e.err = err; e.name = nm;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: compare DUT outputs mid-cycle against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.name, "choseOH",  {6'd0, io_choseOH},     {6'd0, e.oh});
                check(e.name, "in_ready", {6'd0, io_in_ready},    {6'd0, e.rdy});
                check(e.name, "out_vld",  {7'd0, io_out_valid},   {7'd0, e.ov});
                check(e.name, "locked",   {7'd0, io_locked},      {7'd0, e.lock});
                check(e.name, "beat_cnt", {4'd0, io_beat_cnt},    {4'd0, e.cnt});
                check(e.name, "err",      {7'd0, io_err_overrun}, {7'd0, e.err});
            end
        end
    end

    initial begin
        reset        = 1'b0;
        io_in_valid  = '0;
        io_in_last   = '0;
        io_out_ready = 1'b0;

        //   rst  valid  last   ordy chk oh     rdy    ov   lk   cnt  err
        step(0, 2'b11, 2'b11, 1, 0, 2'b00, 2'b00, 0, 0, 4'd0, 0, "rst0");
        step(0, 2'b11, 2'b11, 1, 1, 2'b00, 2'b00, 0, 0, 4'd0, 0, "rst1");

        // alternating single-beat grants
        step(1, 2'b11, 2'b11, 1, 1, 2'b01, 2'b01, 1, 0, 4'd0, 0, "rr1");
        step(1, 2'b11, 2'b11, 1, 1, 2'b10, 2'b10, 1, 0, 4'd0, 0, "rr2");
        step(1, 2'b11, 2'b11, 1, 1, 2'b01, 2'b01, 1, 0, 4'd0, 0, "rr3");
        step(1, 2'b11, 2'b11, 1, 1, 2'b10, 2'b10, 1, 0, 4'd0, 0, "rr4");

        // req0 4-beat burst with req1 waiting
        step(1, 2'b11, 2'b10, 1, 1, 2'b01, 2'b01, 1, 0, 4'd0, 0, "bst1");
        step(1, 2'b11, 2'b10, 1, 1, 2'b01, 2'b01, 1, 1, 4'd1, 0, "bst2");
        step(1, 2'b11, 2'b10, 1, 1, 2'b01, 2'b01, 1, 1, 4'd2, 0, "bst3");
        step(1, 2'b11, 2'b11, 1, 1, 2'b01, 2'b01, 1, 1, 4'd3, 0, "bst4");
        step(1, 2'b11, 2'b11, 1, 1, 2'b10, 2'b10, 1, 0, 4'd0, 0, "bst_nxt");

        // req0 bubbles mid-burst
        step(1, 2'b11, 2'b10, 1, 1, 2'b01, 2'b01, 1, 0, 4'd0, 0, "bub1");
        step(1, 2'b10, 2'b10, 1, 1, 2'b01, 2'b01, 0, 1, 4'd1, 0, "bub2");
        step(1, 2'b10, 2'b10, 1, 1, 2'b01, 2'b01, 0, 1, 4'd1, 0, "bub3");
        step(1, 2'b11, 2'b11, 1, 1, 2'b01, 2'b01, 1, 1, 4'd1, 0, "bub4");
        step(1, 2'b11, 2'b11, 1, 1, 2'b10, 2'b10, 1, 0, 4'd0, 0, "bub_nxt");

        // downstream stall
        step(1, 2'b01, 2'b01, 0, 1, 2'b01, 2'b00, 1, 0, 4'd0, 0, "stall1");
        step(1, 2'b01, 2'b01, 0, 1, 2'b01, 2'b00, 1, 0, 4'd0, 0, "stall2");

        // overrun: nine non-last beats, then last
        for (int k = 0; k < 9; k++) begin
            step(1, 2'b01, 2'b00, 1, 1, 2'b01, 2'b01, 1, (k > 0), (k > 8) ? 4'd8 : 4'(k),
                 (k == 8), $sformatf("ovr%0d", k + 1));
        end
        step(1, 2'b01, 2'b01, 1, 1, 2'b01, 2'b01, 1, 1, 4'd8, 1, "ovr_last");
        step(1, 2'b11, 2'b11, 1, 1, 2'b10, 2'b10, 1, 0, 4'd0, 1, "ovr_nxt");

        // reset during a req1 burst at beat 3
        step(1, 2'b01, 2'b01, 1, 1, 2'b01, 2'b01, 1, 0, 4'd0, 1, "mr_pre");
        step(1, 2'b11, 2'b00, 1, 1, 2'b10, 2'b10, 1, 0, 4'd0, 1, "mr1");
        step(1, 2'b11, 2'b00, 1, 1, 2'b10, 2'b10, 1, 1, 4'd1, 1, "mr2");
        step(1, 2'b11, 2'b00, 1, 1, 2'b10, 2'b10, 1, 1, 4'd2, 1, "mr3");
        step(0, 2'b11, 2'b00, 1, 1, 2'b00, 2'b00, 0, 0, 4'd3, 1, "mr_rst");
        step(1, 2'b11, 2'b11, 1, 1, 2'b01, 2'b01, 1, 0, 4'd0, 0, "mr_after");
        step(1, 2'b11, 2'b11, 1, 1, 2'b10, 2'b10, 1, 0, 4'd0, 0, "mr_after2");

        @(negedge clock);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
